// File: rtl/phase_mac_if.sv
// Bundle between the one-hot sequencer and the phase-driven MAC datapath.
// The sequencer side drives phase and operands; the datapath returns results and status.
interface phase_mac_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
);
  logic [3:0]              phase;
  logic signed [WIDTH-1:0] a_in;
  logic signed [WIDTH-1:0] b_in;
  logic [1:0]              op_in;
  logic signed [ACC_W-1:0] acc_out;
  logic                    done;
  logic                    busy;
  logic                    sat;
  logic                    err;
  logic [CNT_W-1:0]        op_count;

  modport master (
    output phase, a_in, b_in, op_in,
    input  acc_out, done, busy, sat, err, op_count
  );

  modport slave (
    input  phase, a_in, b_in, op_in,
    output acc_out, done, busy, sat, err, op_count
  );
endinterface

// File: rtl/phase_mac.sv
// Saturating signed multiply-accumulate stepped by a one-hot S1/S2/S3 phase bus:
// operands are captured in S2, executed in S3, and the result is reported during the next S1.
module phase_mac #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  phase_mac_if.slave   bus
);
  localparam int XW = ACC_W + 2;
  localparam logic signed [XW-1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [XW-1:0] ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ARMED = 1'b1} state_t;

  state_t                  state_r, state_s;
  logic                    is_s2_s, is_s3_s, is_bad_s;
  logic                    exec_s, fault_s;
  logic signed [WIDTH-1:0] a_r, b_r;
  logic [1:0]              op_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    done_r, sat_r, err_r;
  logic [CNT_W-1:0]        op_count_r;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [XW-1:0]    acc_x_s, a_x_s, p_x_s, sum_s;
  logic signed [ACC_W-1:0] acc_nxt_s;
  logic                    clamp_s;

  // Clamp a widened result into the accumulator range; the top bit flags a clamp.
  function automatic logic [ACC_W:0] sat_clamp(input logic signed [XW-1:0] x);
    logic [ACC_W:0] r;
    if (x > ACC_MAX) begin
      r = {1'b1, ACC_MAX[ACC_W-1:0]};
    end else if (x < ACC_MIN) begin
      r = {1'b1, ACC_MIN[ACC_W-1:0]};
    end else begin
      r = {1'b0, x[ACC_W-1:0]};
    end
    return r;
  endfunction

  // Decode the one-hot phase bus; anything other than S1/S2/S3 is illegal.
  always_comb begin
    is_s2_s  = 1'b0;
    is_s3_s  = 1'b0;
    is_bad_s = 1'b0;
    case (bus.phase)
      4'b0001: is_bad_s = 1'b0;
      4'b0010: is_s2_s  = 1'b1;
      4'b0100: is_s3_s  = 1'b1;
      default: is_bad_s = 1'b1;
    endcase
  end

  // Operand-armed state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: capture arms, execute or an illegal phase disarms.
  always_comb begin
    state_s = state_r;
    if (is_s2_s) begin
      state_s = ST_ARMED;
    end else if (is_s3_s || is_bad_s) begin
      state_s = ST_IDLE;
    end else begin
      state_s = state_r;
    end
  end

  // Control strobes and registered output drive.
  always_comb begin
    exec_s       = is_s3_s && (state_r == ST_ARMED);
    fault_s      = is_bad_s || (is_s3_s && (state_r == ST_IDLE));
    bus.busy     = (state_r == ST_ARMED);
    bus.acc_out  = acc_r;
    bus.done     = done_r;
    bus.sat      = sat_r;
    bus.err      = err_r;
    bus.op_count = op_count_r;
  end

  // Arithmetic in ACC_W+2 bits so no intermediate can wrap before clamping.
  always_comb begin
    prod_s  = a_r * b_r;
    acc_x_s = {{2{acc_r[ACC_W-1]}}, acc_r};
    a_x_s   = {{(XW-WIDTH){a_r[WIDTH-1]}}, a_r};
    p_x_s   = {{(XW-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
    case (op_r)
      2'b00:   sum_s = acc_x_s + a_x_s;
      2'b01:   sum_s = acc_x_s - a_x_s;
      2'b10:   sum_s = acc_x_s + p_x_s;
      2'b11:   sum_s = {XW{1'b0}};
      default: sum_s = acc_x_s;
    endcase
    {clamp_s, acc_nxt_s} = sat_clamp(sum_s);
  end

  // Datapath registers, sticky flags and the wrapping operation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      op_r       <= 2'b00;
      acc_r      <= {ACC_W{1'b0}};
      done_r     <= 1'b0;
      sat_r      <= 1'b0;
      err_r      <= 1'b0;
      op_count_r <= {CNT_W{1'b0}};
    end else begin
      done_r <= exec_s;
      if (fault_s) begin
        err_r <= 1'b1;
      end
      if (is_s2_s) begin
        a_r  <= bus.a_in;
        b_r  <= bus.b_in;
        op_r <= bus.op_in;
      end
      if (exec_s) begin
        op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (op_r == 2'b11) begin
          acc_r <= {ACC_W{1'b0}};
          sat_r <= 1'b0;
        end else begin
          acc_r <= acc_nxt_s;
          if (clamp_s) begin
            sat_r <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_phase_mac.sv
// Randomised and directed bench for phase_mac with an integer reference model
// of the S1/S2/S3 pass behaviour, compared on every falling clock edge.
module tb_phase_mac;
  localparam int W     = 8;
  localparam int AW    = 20;
  localparam int CW    = 8;
  localparam logic [3:0] S1 = 4'b0001;
  localparam logic [3:0] S2 = 4'b0010;
  localparam logic [3:0] S3 = 4'b0100;
  localparam longint MAXV = (64'sd1 <<< (AW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW-1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  phase_mac_if #(.WIDTH(W), .ACC_W(AW), .CNT_W(CW)) bus ();
  phase_mac #(.WIDTH(W), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  longint m_acc;
  bit     m_done, m_busy, m_sat, m_err;
  int     m_cnt, m_a, m_b, m_op;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    longint r;
    if (reset) begin
      m_acc = 0; m_done = 0; m_busy = 0; m_sat = 0; m_err = 0;
      m_cnt = 0; m_a = 0; m_b = 0; m_op = 0;
    end else begin
      m_done = 0;
      if (bus.phase == S1) begin
        m_done = 0;
      end else if (bus.phase == S2) begin
        m_a = int'(bus.a_in); m_b = int'(bus.b_in); m_op = int'(bus.op_in);
        m_busy = 1;
      end else if (bus.phase == S3) begin
        if (m_busy) begin
          if (m_op == 3) begin
            m_acc = 0; m_sat = 0;
          end else begin
            if (m_op == 0) r = m_acc + m_a;
            else if (m_op == 1) r = m_acc - m_a;
            else r = m_acc + longint'(m_a) * longint'(m_b);
            if (r > MAXV) begin r = MAXV; m_sat = 1; end
            if (r < MINV) begin r = MINV; m_sat = 1; end
            m_acc = r;
          end
          m_busy = 0; m_done = 1;
          m_cnt = (m_cnt + 1) % (1 << CW);
        end else begin
          m_err = 1;
        end
      end else begin
        m_err = 1; m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("acc_out",  longint'(bus.acc_out), m_acc);
    check("done",     longint'(bus.done), longint'(m_done));
    check("busy",     longint'(bus.busy), longint'(m_busy));
    check("sat",      longint'(bus.sat), longint'(m_sat));
    check("err",      longint'(bus.err), longint'(m_err));
    check("op_count", longint'(bus.op_count), longint'(m_cnt));
  end

  task automatic step(input logic [3:0] ph, input int a, input int b, input logic [1:0] op);
    bus.phase = ph;
    bus.a_in  = W'(a);
    bus.b_in  = W'(b);
    bus.op_in = op;
    @(posedge clk);
    #1;
  endtask

  task automatic do_pass(input logic [1:0] op, input int a, input int b);
    step(S1, 0, 0, 2'b00);
    step(S2, a, b, op);
    step(S3, 0, 0, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.phase = S1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.phase = S1; bus.a_in = '0; bus.b_in = '0; bus.op_in = 2'b00;
    do_reset();
    check("rst_acc", longint'(bus.acc_out), 0);
    check("rst_cnt", longint'(bus.op_count), 0);

    // Single ADD pass
    step(S1, 0, 0, 2'b00);
    check("t1_busy_s1", longint'(bus.busy), 0);
    step(S2, 5, 0, 2'b00);
    check("t1_busy_s3", longint'(bus.busy), 1);
    step(S3, 0, 0, 2'b00);
    check("t1_acc", longint'(bus.acc_out), 5);
    check("t1_done", longint'(bus.done), 1);
    check("t1_cnt", longint'(bus.op_count), 1);
    check("t1_busy_after", longint'(bus.busy), 0);
    step(S1, 0, 0, 2'b00);
    check("t1_done_clear", longint'(bus.done), 0);

    // Positive saturation
    do_reset();
    for (int i = 0; i < 31; i++) do_pass(2'b10, -128, -128);
    check("t2_acc31", longint'(bus.acc_out), 507904);
    check("t2_sat31", longint'(bus.sat), 0);
    do_pass(2'b10, -128, -128);
    check("t2_acc32", longint'(bus.acc_out), 524287);
    check("t2_sat32", longint'(bus.sat), 1);

    // Negative saturation then CLR
    do_reset();
    for (int i = 0; i < 33; i++) do_pass(2'b10, -128, 127);
    check("t3_acc", longint'(bus.acc_out), -524288);
    check("t3_sat", longint'(bus.sat), 1);
    do_pass(2'b11, 0, 0);
    check("t3_clr_acc", longint'(bus.acc_out), 0);
    check("t3_clr_sat", longint'(bus.sat), 0);
    check("t3_clr_cnt", longint'(bus.op_count), 34);

    // Illegal phase discards the capture
    step(S1, 0, 0, 2'b00);
    step(S2, 9, 0, 2'b00);
    step(4'b0110, 0, 0, 2'b00);
    check("t4_err", longint'(bus.err), 1);
    check("t4_busy", longint'(bus.busy), 0);
    step(S3, 0, 0, 2'b00);
    check("t4_nodone", longint'(bus.done), 0);
    check("t4_acc_hold", longint'(bus.acc_out), 0);
    do_pass(2'b00, 3, 0);
    check("t4_acc_add", longint'(bus.acc_out), 3);
    check("t4_err_sticky", longint'(bus.err), 1);

    // Reset during execute aborts
    step(S1, 0, 0, 2'b00);
    step(S2, 7, 0, 2'b00);
    bus.phase = S3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_acc", longint'(bus.acc_out), 0);
    check("t5_done", longint'(bus.done), 0);
    check("t5_cnt", longint'(bus.op_count), 0);
    check("t5_err", longint'(bus.err), 0);

    // Counter wrap
    for (int i = 0; i < 255; i++) do_pass(2'b00, 0, 0);
    check("t6_cnt255", longint'(bus.op_count), 255);
    do_pass(2'b00, 0, 0);
    check("t6_cnt_wrap", longint'(bus.op_count), 0);
    check("t6_sat", longint'(bus.sat), 0);

    // Randomised phase and operand traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic [3:0] ph;
      sel = $urandom_range(0, 19);
      if (sel < 6) ph = S1;
      else if (sel < 12) ph = S2;
      else if (sel < 18) ph = S3;
      else if (sel == 18) ph = 4'($urandom_range(0, 15));
      else ph = 4'b1000;
      step(ph, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/phase_mac.md
# phase_mac

Sequenced multiply-accumulate datapath that sits directly downstream of the one-hot sequencer (`ohsm`). It consumes the sequencer's one-hot phase bus `SGlobal` and performs the following per pass:
- Captures operands in phase S2.
- Executes one accumulator operation in phase S3.
- Reports completion while the sequencer is back in S1.

It provides saturating signed arithmetic, a completed-operation counter and a sticky error flag for illegal phase codes.

## Interface
- `WIDTH`, default 8: signed operand width of `a_in` and `b_in`.
- `ACC_W`, default 20: signed accumulator width. It must be ≥ 2*`WIDTH`+1.
- `CNT_W`, default 8: width of the operation counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `phase`  in  4  one-hot phase, connected to `SGlobal`:
  - 0001 = S1 idle.
  - 0010 = S2 capture.
  - 0100 = S3 execute.
  - All other codes are illegal.
- `a_in`  in  `WIDTH`  signed operand A, sampled in S2.
- `b_in`  in  `WIDTH`  signed operand B, sampled in S2.
- `op_in`  in  2  operation code, sampled in S2:
  - 00 ADD
  - 01 SUB
  - 10 MAC
  - 11 CLR
- `acc_out`  out  `ACC_W`  signed accumulator value.
- `done`  out  1  one-cycle pulse after each executed operation.
- `busy`  out  1  operands captured and awaiting execution.
- `sat`  out  1  sticky saturation flag.
- `err`  out  1  sticky illegal-phase / protocol error flag.
- `op_count`  out  `CNT_W`  number of executed operations; wraps.

## Operation

Reset (asynchronous):
- `acc_out`, `done`, `busy`, `sat`, `err`, `op_count` and the internal operand/op registers all go to 0 immediately.

Capture, S2 (`phase` = 0010):
- On the edge ending this cycle, register `a_in`, `b_in` and `op_in`, and set `busy` to 1.
- A second S2 while `busy` = 1 overwrites the captured values. It does not set `err`.

Execute, S3 (`phase` = 0100) with `busy` = 1, on the edge ending this cycle:
- Update `acc_out` per the operation table below.
- Clear `busy`.
- Set `done` to 1.
- Increment `op_count`.

Execute, S3 with `busy` = 0:
- No arithmetic, no `done`, no count.
- `err` goes to 1.

Idle, S1 (`phase` = 0001):
- No datapath action.
- `done` returns to 0 unless an execute occurred on the previous edge.

Illegal phase (any code other than 0001/0010/0100, including 1000 and 0000):
- `err` goes to 1.
- `busy` goes to 0, discarding the captured operands.
- `acc_out`, `sat` and `op_count` are unchanged.

Operations (signed, computed in `ACC_W`+2 bits after sign-extension):
- ADD: acc + A.
- SUB: acc − A.
- MAC: acc + A*B, where the full 2*`WIDTH` signed product is sign-extended.
- CLR: acc = 0 and `sat` = 0. It still pulses `done` and increments `op_count`.

Saturation (ADD/SUB/MAC):
- A result above 2^(`ACC_W`−1)−1 is clamped to that value.
- A result below −2^(`ACC_W`−1) is clamped to that value.
- Any clamp sets `sat`. `sat` clears only on CLR or reset.

Sticky and counter rules:
- `err` clears only on reset.
- Once `err` = 1, valid phases continue to operate normally.
- `op_count` wraps from 2^`CNT_W`−1 to 0 with no flag.

## Timing
- A single pass spans 3 cycles: S1 → S2 → S3.
- `acc_out` takes its new value on the edge ending S3 and is visible during the following S1 cycle.
- `done` is high for exactly that S1 cycle (one cycle). It is registered, with no combinational path from `phase`.
- Back-to-back passes with `start` held high upstream produce a `done` pulse every 3 cycles.
- `busy` is high for exactly the S3 cycle of a normal pass.
- Reset asserted in any cycle, including during S3 with `busy` = 1, aborts the operation:
  - No `done`.
  - `acc_out` = 0.
  - `op_count` = 0 after release.

## Test plan
1. Reset, then phases 0001, 0010 (a=5, op=00), 0100, 0001 → `busy` high only in the 0100 cycle; `acc_out` = 5, `done` = 1 and `op_count` = 1 in the final 0001 cycle; `done` = 0 the next cycle.
2. MAC with a=−128, b=−128, repeated 32 passes (`ACC_W` = 20) → after 31 passes `acc_out` = 507904, `sat` = 0; after the 32nd, `acc_out` = 524287, `sat` = 1.
3. From 0, MAC with a=−128, b=127, 33 passes → `acc_out` = −524288, `sat` = 1. Then CLR → `acc_out` = 0, `sat` = 0, `op_count` = 34.
4. Drive `phase` = 0110 after a capture, then 0100 → `err` = 1, `busy` = 0 after the illegal cycle, no `done`, `acc_out` unchanged. A following normal ADD a=3 executes (`acc_out` += 3) and `err` stays 1.
5. Assert `reset` during the 0100 cycle of an ADD a=7 → `acc_out` = 0, `done` = 0, `op_count` = 0 after release.
6. 256 consecutive ADD a=0 passes (`CNT_W` = 8) → `op_count` wraps 255 → 0; `acc_out` = 0 and `sat` = 0 throughout.
